display_entry_ctrl: RTL and testbench

DISPLAY_ENTRY_CTRL -- requirements
Module: display_entry_ctrl

---
 rtl/display_entry_ctrl.sv | 164 ++++++++++++++++
 tb/tb_display_entry_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/display_entry_ctrl.sv
// Digit-entry controller: debounced cursor/backspace buttons, keypad writes into a blank-able slot buffer, multiplexed display scan.
// Latency: buffer/cursor update on the edge after a press or key strobe; display and led outputs follow one cycle later. No backpressure.
module display_entry_ctrl #(
   parameter int NUM_DIGITS      = 4,
   parameter int SCAN_DIV        = 262144,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic                            btnR,
   input  logic                            btnL,
   input  logic                            key_valid,
   input  logic [3:0]                      key_val,
   output logic [NUM_DIGITS-1:0]           anode,
   output logic [3:0]                      hex_out,
   output logic [NUM_DIGITS-1:0]           led,
   output logic [$clog2(NUM_DIGITS)-1:0]   cursor,
   output logic                            entry_done,
   output logic [4*NUM_DIGITS-1:0]         entry_value
);

   localparam int CUR_W  = $clog2(NUM_DIGITS);
   localparam int SCAN_W = $clog2(SCAN_DIV);
   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CUR_W-1:0]  LAST      = CUR_W'(NUM_DIGITS - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]        BLANK     = 4'hF;

   // Button index 0 is btnR, index 1 is btnL.
   logic [1:0]      sync1_q, sync1_d;
   logic [1:0]      sync2_q, sync2_d;
   logic [1:0]      lvl_q, lvl_d;
   logic [DB_W-1:0] db_cnt_q [2];
   logic [DB_W-1:0] db_cnt_d [2];
   logic [1:0]      press;

   logic [4*NUM_DIGITS-1:0] buf_q, buf_d;
   logic [CUR_W-1:0]        cur_q, cur_d;
   logic                    done_q, done_d;
   logic [4*NUM_DIGITS-1:0] value_q, value_d;
   logic                    full;

   logic [SCAN_W-1:0]       scan_cnt_q, scan_cnt_d;
   logic [CUR_W-1:0]        idx_q, idx_d;
   logic [NUM_DIGITS-1:0]   anode_q, anode_d;
   logic [3:0]              hex_q, hex_d;
   logic [NUM_DIGITS-1:0]   led_q, led_d;
   logic [3:0]              scan_slot;

   // A level is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
   always_comb begin
      sync1_d = {btnL, btnR};
      sync2_d = sync1_q;
      lvl_d   = lvl_q;
      press   = 2'b00;
      for (int b = 0; b < 2; b++) begin
         db_cnt_d[b] = '0;
         if (sync2_q[b] != lvl_q[b]) begin
            if (db_cnt_q[b] == DB_LAST) begin
               lvl_d[b] = sync2_q[b];
               press[b] = sync2_q[b];
            end else begin
               db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
            end
         end
      end
   end

   always_comb begin
      buf_d   = buf_q;
      cur_d   = cur_q;
      done_d  = 1'b0;
      value_d = value_q;
      full    = 1'b1;
      if (press[1]) begin
         if (buf_q[4*int'(cur_q) +: 4] != BLANK) begin
            buf_d[4*int'(cur_q) +: 4] = BLANK;
         end else if (cur_q != '0) begin
            cur_d = cur_q - CUR_W'(1);
            buf_d[4*int'(cur_d) +: 4] = BLANK;
         end
      end else begin
         if (key_valid && (key_val <= 4'h9 || key_val == BLANK)) begin
            buf_d[4*int'(cur_q) +: 4] = key_val;
         end
         // Commit sees the buffer including a same-cycle key write.
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (buf_d[4*k +: 4] == BLANK) full = 1'b0;
         end
         if (press[0]) begin
            if (cur_q != LAST) begin
               cur_d = cur_q + CUR_W'(1);
            end else if (full) begin
               done_d  = 1'b1;
               value_d = buf_d;
               buf_d   = {NUM_DIGITS{BLANK}};
               cur_d   = '0;
            end
         end
      end
   end

   always_comb begin
      scan_cnt_d = scan_cnt_q + SCAN_W'(1);
      idx_d      = idx_q;
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         idx_d      = (idx_q == LAST) ? '0 : idx_q + CUR_W'(1);
      end
      scan_slot = buf_q[4*int'(idx_q) +: 4];
      anode_d   = '1;
      hex_d     = BLANK;
      if (scan_slot != BLANK) begin
         anode_d[NUM_DIGITS-1-int'(idx_q)] = 1'b0;
         hex_d = scan_slot;
      end
      for (int k = 0; k < NUM_DIGITS; k++) begin
         led_d[k] = (buf_q[4*k +: 4] != BLANK);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         lvl_q       <= '0;
         db_cnt_q[0] <= '0;
         db_cnt_q[1] <= '0;
         buf_q       <= {NUM_DIGITS{BLANK}};
         cur_q       <= '0;
         done_q      <= 1'b0;
         value_q     <= '0;
         scan_cnt_q  <= '0;
         idx_q       <= '0;
         anode_q     <= '1;
         hex_q       <= BLANK;
         led_q       <= '0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         lvl_q       <= lvl_d;
         db_cnt_q[0] <= db_cnt_d[0];
         db_cnt_q[1] <= db_cnt_d[1];
         buf_q       <= buf_d;
         cur_q       <= cur_d;
         done_q      <= done_d;
         value_q     <= value_d;
         scan_cnt_q  <= scan_cnt_d;
         idx_q       <= idx_d;
         anode_q     <= anode_d;
         hex_q       <= hex_d;
         led_q       <= led_d;
      end
   end

   assign anode       = anode_q;
   assign hex_out     = hex_q;
   assign led         = led_q;
   assign cursor      = cur_q;
   assign entry_done  = done_q;
   assign entry_value = value_q;

endmodule

// File: tb/tb_display_entry_ctrl.sv
// Directed bench for display_entry_ctrl with a scoreboard of expected commits and scan frames.
module tb_display_entry_ctrl;

   logic        clock = 1'b0;
   logic        reset_n, btnR, btnL, key_valid;
   logic [3:0]  key_val;
   logic [3:0]  anode;
   logic [3:0]  hex_out;
   logic [3:0]  led;
   logic [1:0]  cursor;
   logic        entry_done;
   logic [15:0] entry_value;

   int tests = 0;
   int fails = 0;
   logic [15:0] exp_q[$];
   logic [7:0]  scan_q[$];
   logic [7:0]  scan_e;

   display_entry_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .DEBOUNCE_CYCLES(4)) dut (
      .clock(clock), .reset_n(reset_n), .btnR(btnR), .btnL(btnL),
      .key_valid(key_valid), .key_val(key_val), .anode(anode), .hex_out(hex_out),
      .led(led), .cursor(cursor), .entry_done(entry_done), .entry_value(entry_value)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every entry_done pulse must match a queued commit.
   always @(negedge clock) begin
      if (reset_n && entry_done) begin
         check("entry_done_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) check("entry_value", 32'(entry_value), 32'(exp_q.pop_front()));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic key(input logic [3:0] v);
      key_val = v; key_valid = 1'b1;
      tick(1);
      key_valid = 1'b0;
   endtask

   // Press pulse fires in the 6th cycle after assertion; optional key strobe lands in that same cycle.
   task automatic press(input bit right, input bit with_key, input logic [3:0] v);
      if (right) btnR = 1'b1; else btnL = 1'b1;
      tick(5);
      if (with_key) begin key_val = v; key_valid = 1'b1; end
      tick(1);
      key_valid = 1'b0; btnR = 1'b0; btnL = 1'b0;
      tick(8);
   endtask

   task automatic pulse_r(input int n);
      btnR = 1'b1;
      tick(n);
      btnR = 1'b0;
      tick(8);
   endtask

   task automatic do_reset();
      reset_n = 1'b0; btnR = 1'b0; btnL = 1'b0; key_valid = 1'b0; key_val = 4'h0;
      tick(2);
      check("reset_state", {anode, hex_out, led, 2'(cursor), entry_done, entry_value},
            {4'hF, 4'hF, 4'h0, 2'd0, 1'b0, 16'h0});
      reset_n = 1'b1;
      tick(1);
   endtask

   initial begin
      reset_n = 1'b0; btnR = 1'b0; btnL = 1'b0; key_valid = 1'b0; key_val = 4'h0;
      do_reset();

      for (int i = 0; i < 64; i++) begin
         check("idle", {anode, hex_out, led, 2'(cursor)}, {4'hF, 4'hF, 4'h0, 2'd0});
         tick(1);
      end

      key(4'h3); press(1, 0, 0);
      key(4'h7); press(1, 0, 0);
      key(4'h1); press(1, 0, 0);
      key(4'h9); tick(1);
      check("full_before_commit", {led, 2'(cursor)}, {4'hF, 2'd3});
      exp_q.push_back(16'h9173);
      press(1, 0, 0);
      check("commit_seen", exp_q.size(), 0);
      check("after_commit", {led, 2'(cursor), entry_value}, {4'h0, 2'd0, 16'h9173});

      key(4'h1); press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
      check("cursor_at_last", 32'(cursor), 3);
      press(1, 0, 0);
      check("no_wrap_no_commit", {led, 2'(cursor), entry_value}, {4'h1, 2'd3, 16'h9173});

      do_reset();
      check("reset_discards", {led, 2'(cursor), entry_value}, {4'h0, 2'd0, 16'h0});
      key(4'h1); press(1, 0, 0);
      key(4'h2); press(1, 0, 0);
      key(4'h3); press(1, 0, 0);
      exp_q.push_back(16'h4321);
      press(1, 1, 4'h4);
      check("key_with_commit", {led, 2'(cursor), entry_value}, {4'h0, 2'd0, 16'h4321});

      pulse_r(3);
      pulse_r(3);
      check("glitch_rejected", 32'(cursor), 0);
      pulse_r(6);
      check("hold_advances", 32'(cursor), 1);
      pulse_r(20);
      check("hold_no_repeat", 32'(cursor), 2);

      do_reset();
      key(4'h5); press(1, 0, 0); press(1, 0, 0); key(4'h2); tick(1);
      check("scan_setup", {led, 2'(cursor)}, {4'h5, 2'd2});
      for (int c = 0; c < 4; c++) scan_q.push_back({4'b0111, 4'h5});
      for (int c = 0; c < 4; c++) scan_q.push_back({4'b1111, 4'hF});
      for (int c = 0; c < 4; c++) scan_q.push_back({4'b1101, 4'h2});
      for (int c = 0; c < 4; c++) scan_q.push_back({4'b1111, 4'hF});
      for (int i = 0; i < 64 && anode == 4'b0111; i++) tick(1);
      for (int i = 0; i < 64 && anode != 4'b0111; i++) tick(1);
      check("scan_sync", 32'(anode), 32'h7);
      while (scan_q.size() > 0) begin
         scan_e = scan_q.pop_front();
         check("scan", {anode, hex_out}, scan_e);
         tick(1);
      end

      do_reset();
      key(4'h5); press(1, 0, 0); key(4'h6); press(1, 0, 0);
      check("bksp_setup", {led, 2'(cursor)}, {4'h3, 2'd2});
      press(0, 0, 0);
      check("bksp_blank_moves", {led, 2'(cursor)}, {4'h1, 2'd1});
      press(0, 0, 0);
      check("bksp_to_zero", {led, 2'(cursor)}, {4'h0, 2'd0});
      press(0, 0, 0);
      check("bksp_at_zero", {led, 2'(cursor)}, {4'h0, 2'd0});

      key(4'hB); tick(1);
      check("reserved_ignored", 32'(led), 0);
      press(0, 1, 4'h8);
      check("key_dropped_bksp", {led, 2'(cursor)}, {4'h0, 2'd0});
      key(4'h8); tick(1);
      check("key_write", 32'(led), 1);

      reset_n = 1'b0; btnR = 1'b1;
      tick(3);
      reset_n = 1'b1;
      tick(3);
      check("held_reset_early", 32'(cursor), 0);
      tick(4);
      check("held_reset_press", 32'(cursor), 1);
      btnR = 1'b0;
      tick(8);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
